acc_core: RTL and testbench
===========================

# acc_core

Parametrised multi-cycle accumulator core: the second-generation processor datapath and control for the design. It fetches one instruction per fetch/execute pair over a req/ack instruction-memory port, so wait states from slow memory are handled. It executes on a WIDTH-bit accumulator with an internal register file and a Z/C flag register, and supports conditional branches and an explicit halt.

## Interface
- WIDTH, 16: accumulator, register, and immediate width.
- ADDR_BITS, 16: program counter width.
- REG_NUM, 16: register-file depth (power of 2, ≥2); RA = log2(REG_NUM).
- clk_in  in  1  clock; all state changes on rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_BITS  fetch address (= pc).
- imem_ack  in  1  fetch data valid this cycle.
- imem_data  in  8+WIDTH  instruction: [WIDTH+7:WIDTH] opcode, [WIDTH-1:0] imm.
- acc_out  out  WIDTH  accumulator.
- pc_out  out  ADDR_BITS  program counter.
- flag_z, flag_c  out  1  zero and carry flags.
- halted  out  1  core in HALT.
- illegal  out  1  1 when HALT was entered on an undefined opcode; held until reset.

## Operation
- Opcodes (imm = immediate, r = imm[RA-1:0], other imm bits ignored):
  - 00 NOP
  - 01 LDI: acc = imm
  - 02 LD: acc = R[r]
  - 03 ST: R[r] = acc
  - 04 ADD: acc += R[r]
  - 05 SUB: acc -= R[r]
  - 06 AND / 07 OR / 08 XOR with R[r]
  - 09 ADDI: acc += imm
  - 10 JMP
  - 11 JZ (if Z)
  - 12 JNZ (if !Z)
  - 13 JC (if C); jump target = imm[ADDR_BITS-1:0], zero-extended if ADDR_BITS > WIDTH
  - FF HLT
  - any other opcode → HALT with illegal = 1
- Flags:
  - Z = (result == 0) after LDI, LD, ADD, SUB, AND, OR, XOR, ADDI.
  - C = carry-out for ADD/ADDI; C = borrow (R[r] > acc, unsigned) for SUB.
  - AND/OR/XOR clear C; LDI/LD leave C unchanged.
  - ST, NOP, and jumps leave both flags unchanged.
- Arithmetic is modulo 2^WIDTH, unsigned.
- PC increments modulo 2^ADDR_BITS; 0 follows all-ones.
- FSM states: FETCH, EXEC, HALT.
  - FETCH: imem_req = 1, imem_addr = pc. On imem_ack: latch imem_data into IR → EXEC. Without ack, stay in FETCH and hold the address stable.
  - EXEC: imem_req = 0. Apply the instruction; pc = taken ? target : pc+1. → FETCH, or → HALT for HLT/illegal (pc then points at the HLT instruction, not incremented).
  - HALT: imem_req = 0, halted = 1. No state changes; exit only via reset.
- Register file reads combinationally from R[r] and writes at the EXEC edge. An ST followed by an LD of the same r returns the stored value.

## Timing
- Reset (rst_in low, asynchronous):
  - pc = 0, acc = 0, all R = 0, Z = 0, C = 0, illegal = 0, halted = 0, imem_req = 0.
  - State = FETCH; imem_req asserts on the first edge after release.
- Reset asserted mid-fetch or mid-exec: outputs take reset values immediately, with no pending write.
- Throughput: 2 cycles per instruction with zero-wait ack (ack in the first FETCH cycle); each wait cycle adds one.
- acc, flags, register, and pc updates are visible the cycle after EXEC.
- imem_ack outside FETCH is ignored.
- A taken jump to its own address loops forever; this is legal.

## Test plan
- Arithmetic and flags:
  - Program LDI 5; ADDI 3; ST R2; LDI 0; ADD R2; HLT.
  - Required: acc = 8, R2 = 8, Z = 0, C = 0, halted = 1, pc = 5. Total 12 cycles from reset release with zero-wait ack.
- Carry and borrow (WIDTH = 16):
  - LDI FFFF; ADDI 1 → acc = 0, Z = 1, C = 1.
  - Then ST R0; LDI 1; SUB R0 → acc = 1, C = 0.
  - Then LDI 0; ST R1; LDI 0; SUB... Simpler form: LDI 3; ST R1; LDI 2; SUB R1 → acc = FFFF, C = 1, Z = 0.
- Branches:
  - LDI 0; JZ 4; LDI 7; HLT; LDI 9; JNZ 7; NOP; HLT.
  - Required: acc = 9, halted at pc = 7. The instruction at address 2 is never executed.
- Wait states: repeat the first program with imem_ack delayed 3 cycles per fetch.
  - Required: identical final state, 30 cycles total, imem_addr stable while req is high and ack is low.
- Illegal opcode and PC wrap:
  - Opcode 0x42 at pc 0 → HALT, illegal = 1, pc = 0.
  - With ADDR_BITS = 4: NOPs at 0..15, then HLT at 0 on the second pass, pc visits 15 → 0.
- Async reset:
  - Pull rst_in low mid-EXEC of an ST.
  - Required: outputs reset immediately, no register written; re-run from pc 0 after release.

Source files
------------

// File: rtl/acc_core_if.sv
// Instruction-memory port of acc_core: a req/ack fetch handshake.
//   imem_req   core -> mem  fetch request, held until acknowledged
//   imem_addr  core -> mem  fetch address (the core's pc)
//   imem_ack   mem -> core  imem_data is valid this cycle
//   imem_data  mem -> core  {opcode[7:0], imm[WIDTH-1:0]}
interface acc_core_if #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ADDR_BITS = 16
);
    logic                 imem_req;
    logic [ADDR_BITS-1:0] imem_addr;
    logic                 imem_ack;
    logic [WIDTH+7:0]     imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/acc_core.sv
// Multi-cycle accumulator core: FETCH/EXEC/HALT control, WIDTH-bit accumulator,
// REG_NUM-entry register file and Z/C flags.
//   clk_in          clock, rising edge
//   rst_in          asynchronous active-low reset
//   imem            instruction fetch port (acc_core_if master)
//   acc_out         accumulator
//   pc_out          program counter
//   flag_z, flag_c  zero / carry flags
//   halted          core is in HALT
//   illegal         HALT was entered on an undefined opcode
module acc_core #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned REG_NUM   = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    acc_core_if.master           imem,
    output logic [WIDTH-1:0]     acc_out,
    output logic [ADDR_BITS-1:0] pc_out,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic                 halted,
    output logic                 illegal
);
    localparam int unsigned RA = (REG_NUM > 2) ? $clog2(REG_NUM) : 1;
    localparam int unsigned IW = WIDTH + 8;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LDI  = 8'h01;
    localparam logic [7:0] OP_LD   = 8'h02;
    localparam logic [7:0] OP_ST   = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h04;
    localparam logic [7:0] OP_SUB  = 8'h05;
    localparam logic [7:0] OP_AND  = 8'h06;
    localparam logic [7:0] OP_OR   = 8'h07;
    localparam logic [7:0] OP_XOR  = 8'h08;
    localparam logic [7:0] OP_ADDI = 8'h09;
    localparam logic [7:0] OP_JMP  = 8'h10;
    localparam logic [7:0] OP_JZ   = 8'h11;
    localparam logic [7:0] OP_JNZ  = 8'h12;
    localparam logic [7:0] OP_JC   = 8'h13;
    localparam logic [7:0] OP_HLT  = 8'hFF;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IW-1:0]        r_ir;
    logic [ADDR_BITS-1:0] r_pc;
    logic [WIDTH-1:0]     r_acc;
    logic                 r_z;
    logic                 r_c;
    logic                 r_halted;
    logic                 r_illegal;
    logic                 r_req;
    logic [WIDTH-1:0]     r_rf [REG_NUM];

    logic [7:0]           w_op;
    logic [WIDTH-1:0]     w_imm;
    logic [RA-1:0]        w_r;
    logic [WIDTH-1:0]     w_rv;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_addi;
    logic [WIDTH:0]       w_diff;
    logic [ADDR_BITS-1:0] w_pc_inc;
    logic [ADDR_BITS-1:0] w_target;
    logic [WIDTH-1:0]     w_acc_nxt;
    logic [ADDR_BITS-1:0] w_pc_nxt;
    logic                 w_z_nxt;
    logic                 w_c_nxt;
    logic                 w_rf_we;
    logic                 w_stop;
    logic                 w_bad;
    logic                 w_fetch_done;

    assign w_op     = r_ir[IW-1:WIDTH];
    assign w_imm    = r_ir[WIDTH-1:0];
    assign w_r      = r_ir[RA-1:0];
    assign w_rv     = r_rf[w_r];
    // One extra bit carries the carry-out; for the subtract it holds the borrow.
    assign w_sum    = {1'b0, r_acc} + {1'b0, w_rv};
    assign w_addi   = {1'b0, r_acc} + {1'b0, w_imm};
    assign w_diff   = {1'b0, r_acc} - {1'b0, w_rv};
    assign w_pc_inc = r_pc + ADDR_BITS'(1);
    assign w_target = ADDR_BITS'(w_imm);
    // r_req is low in the first FETCH cycle after reset, so a stray ack there is ignored.
    assign w_fetch_done = (r_state == S_FETCH) && r_req && imem.imem_ack;

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: if (w_fetch_done) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = w_stop ? S_HALT : S_FETCH;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Instruction decode: next datapath values for the EXEC edge
    always_comb begin
        w_acc_nxt = r_acc;
        w_z_nxt   = r_z;
        w_c_nxt   = r_c;
        w_pc_nxt  = w_pc_inc;
        w_rf_we   = 1'b0;
        w_stop    = 1'b0;
        w_bad     = 1'b0;
        case (w_op)
            OP_NOP: begin
            end
            OP_LDI: begin
                w_acc_nxt = w_imm;
                w_z_nxt   = (w_imm == '0);
            end
            OP_LD: begin
                w_acc_nxt = w_rv;
                w_z_nxt   = (w_rv == '0);
            end
            OP_ST: w_rf_we = 1'b1;
            OP_ADD: begin
                w_acc_nxt = w_sum[WIDTH-1:0];
                w_z_nxt   = (w_sum[WIDTH-1:0] == '0);
                w_c_nxt   = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_acc_nxt = w_diff[WIDTH-1:0];
                w_z_nxt   = (w_diff[WIDTH-1:0] == '0);
                w_c_nxt   = w_diff[WIDTH];
            end
            OP_AND: begin
                w_acc_nxt = r_acc & w_rv;
                w_z_nxt   = ((r_acc & w_rv) == '0);
                w_c_nxt   = 1'b0;
            end
            OP_OR: begin
                w_acc_nxt = r_acc | w_rv;
                w_z_nxt   = ((r_acc | w_rv) == '0);
                w_c_nxt   = 1'b0;
            end
            OP_XOR: begin
                w_acc_nxt = r_acc ^ w_rv;
                w_z_nxt   = ((r_acc ^ w_rv) == '0);
                w_c_nxt   = 1'b0;
            end
            OP_ADDI: begin
                w_acc_nxt = w_addi[WIDTH-1:0];
                w_z_nxt   = (w_addi[WIDTH-1:0] == '0);
                w_c_nxt   = w_addi[WIDTH];
            end
            OP_JMP: w_pc_nxt = w_target;
            OP_JZ:  if (r_z)  w_pc_nxt = w_target;
            OP_JNZ: if (!r_z) w_pc_nxt = w_target;
            OP_JC:  if (r_c)  w_pc_nxt = w_target;
            OP_HLT: begin
                w_stop   = 1'b1;
                w_pc_nxt = r_pc;
            end
            default: begin
                w_stop   = 1'b1;
                w_bad    = 1'b1;
                w_pc_nxt = r_pc;
            end
        endcase
    end

    // Datapath, register file and registered handshake outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_ir      <= '0;
            r_pc      <= '0;
            r_acc     <= '0;
            r_z       <= 1'b0;
            r_c       <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_req     <= 1'b0;
            for (int i = 0; i < int'(REG_NUM); i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_req <= (w_state_nxt == S_FETCH);
            if (w_fetch_done) begin
                r_ir <= imem.imem_data;
            end
            if (r_state == S_EXEC) begin
                r_acc <= w_acc_nxt;
                r_pc  <= w_pc_nxt;
                r_z   <= w_z_nxt;
                r_c   <= w_c_nxt;
                if (w_stop) r_halted <= 1'b1;
                if (w_bad)  r_illegal <= 1'b1;
                if (w_rf_we) r_rf[w_r] <= r_acc;
            end
        end
    end

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_pc;
    assign acc_out        = r_acc;
    assign pc_out         = r_pc;
    assign flag_z         = r_z;
    assign flag_c         = r_c;
    assign halted         = r_halted;
    assign illegal        = r_illegal;
endmodule

// File: tb/tb_acc_core.sv
// Self-checking bench for acc_core: reset values, a table of single-operation
// vectors, hand-written programs (arithmetic, wait states, branches, illegal
// opcode, async reset mid-ST, PC wrap on a 4-bit-pc instance) and random
// programs compared against an instruction-level reference model.
module tb_acc_core;
    localparam int unsigned W  = 16;
    localparam int unsigned AB = 16;
    localparam int unsigned RN = 16;

    localparam logic [7:0] NOP  = 8'h00;
    localparam logic [7:0] LDI  = 8'h01;
    localparam logic [7:0] LD   = 8'h02;
    localparam logic [7:0] ST   = 8'h03;
    localparam logic [7:0] ADD  = 8'h04;
    localparam logic [7:0] SUB  = 8'h05;
    localparam logic [7:0] ANDO = 8'h06;
    localparam logic [7:0] ORO  = 8'h07;
    localparam logic [7:0] XORO = 8'h08;
    localparam logic [7:0] ADDI = 8'h09;
    localparam logic [7:0] JMP  = 8'h10;
    localparam logic [7:0] JZ   = 8'h11;
    localparam logic [7:0] JNZ  = 8'h12;
    localparam logic [7:0] JC   = 8'h13;
    localparam logic [7:0] HLT  = 8'hFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst4_n;

    acc_core_if #(.WIDTH(W), .ADDR_BITS(AB)) bus ();
    acc_core_if #(.WIDTH(W), .ADDR_BITS(4))  bus4 ();

    logic [W-1:0]  acc;
    logic [AB-1:0] pc;
    logic          fz, fc, halted, illegal;
    logic [W-1:0]  acc4;
    logic [3:0]    pc4;
    logic          fz4, fc4, halted4, illegal4;

    acc_core #(.WIDTH(W), .ADDR_BITS(AB), .REG_NUM(RN)) dut (
        .clk_in(clk), .rst_in(rst_n), .imem(bus),
        .acc_out(acc), .pc_out(pc), .flag_z(fz), .flag_c(fc),
        .halted(halted), .illegal(illegal)
    );

    acc_core #(.WIDTH(W), .ADDR_BITS(4), .REG_NUM(RN)) dut4 (
        .clk_in(clk), .rst_in(rst4_n), .imem(bus4),
        .acc_out(acc4), .pc_out(pc4), .flag_z(fz4), .flag_c(fc4),
        .halted(halted4), .illegal(illegal4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0]   prog [256];
    int            wait_n = 0;
    bit            stray  = 1'b0;
    int            unstable = 0;
    logic [AB-1:0] fetch_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = {HLT, 16'h0000};
    endtask

    // Instruction memory for the main instance: wait_n wait cycles per fetch,
    // optional stray acks with junk data while no request is pending.
    int            mcnt = 0;
    logic          p_req = 1'b0;
    logic          p_ack = 1'b0;
    logic [AB-1:0] p_addr = '0;
    always @(negedge clk) begin
        if (!rst_n) fetch_log.delete();
        if (bus.imem_req && p_req && !p_ack && bus.imem_addr != p_addr) unstable++;
        p_req  = bus.imem_req;
        p_addr = bus.imem_addr;
        if (!bus.imem_req) begin
            mcnt = 0;
            bus.imem_ack  = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.imem_data = 24'($urandom);
        end else if (mcnt >= wait_n) begin
            bus.imem_ack  = 1'b1;
            bus.imem_data = prog[bus.imem_addr[7:0]];
            fetch_log.push_back(bus.imem_addr);
            mcnt = 0;
        end else begin
            bus.imem_ack  = 1'b0;
            bus.imem_data = 24'($urandom);
            mcnt++;
        end
        p_ack = bus.imem_ack;
    end

    // Memory for the 4-bit-pc instance: 16 NOPs, then HLT on the second visit to 0.
    int f4 = 0;
    always @(negedge clk) begin
        if (!rst4_n) f4 = 0;
        if (!bus4.imem_req) begin
            bus4.imem_ack  = 1'b0;
            bus4.imem_data = '0;
        end else begin
            bus4.imem_ack  = 1'b1;
            bus4.imem_data = (f4 >= 16 && bus4.imem_addr == 4'd0) ? {HLT, 16'h0} : {NOP, 16'h0};
            f4++;
        end
    end

    // Reset, release, and count cycles from the first requesting cycle until halted.
    task automatic run_prog(input int budget, output int cycles);
        bit started;
        started = 1'b0;
        cycles  = 0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (started) cycles++;
            else if (bus.imem_req) started = 1'b1;
            if (halted) break;
        end
        check("halt_within_budget", 32'(halted), 32'd1);
    endtask

    // Reference: interpret the program instruction by instruction.
    task automatic model(output int unsigned e_acc, output bit e_z, output bit e_c,
                         output bit e_ill, output int unsigned e_pc, output int unsigned e_n);
        int unsigned rf [16];
        int unsigned imm, rv, s, nxt;
        logic [7:0]  op;
        bit          running;
        e_acc = 0; e_z = 0; e_c = 0; e_ill = 0; e_pc = 0; e_n = 0;
        for (int i = 0; i < 16; i++) rf[i] = 0;
        running = 1'b1;
        while (running && e_n < 1000) begin
            op  = prog[8'(e_pc)][23:16];
            imm = 32'(prog[8'(e_pc)][15:0]);
            rv  = rf[imm % 16];
            nxt = (e_pc + 1) % 65536;
            e_n++;
            case (op)
                NOP: ;
                LDI:  begin e_acc = imm; e_z = (e_acc == 0); end
                LD:   begin e_acc = rv;  e_z = (e_acc == 0); end
                ST:   rf[imm % 16] = e_acc;
                ADD:  begin s = e_acc + rv;  e_c = (s > 65535); e_acc = s % 65536; e_z = (e_acc == 0); end
                ADDI: begin s = e_acc + imm; e_c = (s > 65535); e_acc = s % 65536; e_z = (e_acc == 0); end
                SUB:  begin e_c = (rv > e_acc); e_acc = (e_acc + 65536 - rv) % 65536; e_z = (e_acc == 0); end
                ANDO: begin e_acc = e_acc & rv; e_c = 0; e_z = (e_acc == 0); end
                ORO:  begin e_acc = e_acc | rv; e_c = 0; e_z = (e_acc == 0); end
                XORO: begin e_acc = e_acc ^ rv; e_c = 0; e_z = (e_acc == 0); end
                JMP:  nxt = imm;
                JZ:   if (e_z)  nxt = imm;
                JNZ:  if (!e_z) nxt = imm;
                JC:   if (e_c)  nxt = imm;
                HLT:  begin running = 1'b0; nxt = e_pc; end
                default: begin running = 1'b0; e_ill = 1'b1; nxt = e_pc; end
            endcase
            e_pc = nxt;
        end
    endtask

    typedef struct {
        bit          cpre;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  op;
        logic [15:0] eacc;
        bit          ez;
        bit          ec;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [13];
        int   cyc, k;
        int unsigned e_acc, e_pc, e_n;
        bit   e_z, e_c, e_ill, found, wrap;
        logic [7:0]  ops [14];
        logic [AB-1:0] exp_log [5];
        logic [3:0]  prev4;

        vt[0]  = '{1'b0, 16'h0005, 16'h0003, ADD,  16'h0008, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 16'hFFFF, 16'h0001, ADD,  16'h0000, 1'b1, 1'b1};
        vt[2]  = '{1'b0, 16'h0002, 16'h0003, SUB,  16'hFFFF, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 16'h0001, 16'h0000, SUB,  16'h0001, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 16'h0007, 16'h0007, SUB,  16'h0000, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 16'hF0F0, 16'hFF00, ANDO, 16'hF000, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 16'hF0F0, 16'h0F0F, ANDO, 16'h0000, 1'b1, 1'b0};
        vt[7]  = '{1'b1, 16'hF0F0, 16'h0F0F, ORO,  16'hFFFF, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 16'hAAAA, 16'hAAAA, XORO, 16'h0000, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 16'h1234, 16'h0000, LD,   16'h0000, 1'b1, 1'b1};
        vt[10] = '{1'b1, 16'h1234, 16'h0000, LDI,  16'h0000, 1'b1, 1'b1};
        vt[11] = '{1'b0, 16'hFFFE, 16'h0003, ADDI, 16'h0001, 1'b0, 1'b1};
        vt[12] = '{1'b1, 16'h0000, 16'h0009, NOP,  16'h0000, 1'b1, 1'b1};

        rst_n  = 1'b0;
        rst4_n = 1'b0;
        clear_prog();

        // Reset values
        @(negedge clk);
        #1;
        check("reset_acc", 32'(acc), 32'd0);
        check("reset_pc", 32'(pc), 32'd0);
        check("reset_flags", {30'd0, fz, fc}, 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_illegal", 32'(illegal), 32'd0);
        check("reset_req", 32'(bus.imem_req), 32'd0);

        // Arithmetic program, zero-wait then 3 wait cycles per fetch
        for (int pass = 0; pass < 2; pass++) begin
            clear_prog();
            prog[0] = {LDI, 16'd5};
            prog[1] = {ADDI, 16'd3};
            prog[2] = {ST, 16'd2};
            prog[3] = {LDI, 16'd0};
            prog[4] = {ADD, 16'd2};
            prog[5] = {HLT, 16'd0};
            wait_n  = (pass == 0) ? 0 : 3;
            unstable = 0;
            run_prog(200, cyc);
            check($sformatf("arith%0d_acc", pass), 32'(acc), 32'd8);
            check($sformatf("arith%0d_zc", pass), {30'd0, fz, fc}, 32'd0);
            check($sformatf("arith%0d_pc", pass), 32'(pc), 32'd5);
            check($sformatf("arith%0d_cycles", pass), 32'(cyc), (pass == 0) ? 32'd12 : 32'd30);
            check($sformatf("arith%0d_addr_stable", pass), 32'(unstable), 32'd0);
        end
        wait_n = 0;

        // Single-operation vectors
        for (int i = 0; i < 13; i++) begin
            clear_prog();
            k = 0;
            if (vt[i].cpre) begin
                prog[k] = {LDI, 16'hFFFF}; k++;
                prog[k] = {ADDI, 16'h0001}; k++;
            end
            prog[k] = {LDI, vt[i].b}; k++;
            prog[k] = {ST, 16'hFFF5}; k++;
            prog[k] = {LDI, vt[i].a}; k++;
            prog[k] = {vt[i].op, (vt[i].op == LDI || vt[i].op == ADDI) ? vt[i].b : 16'hFFF5}; k++;
            prog[k] = {HLT, 16'h0000};
            run_prog(200, cyc);
            check($sformatf("vec%0d_acc", i), 32'(acc), 32'(vt[i].eacc));
            check($sformatf("vec%0d_z", i), 32'(fz), 32'(vt[i].ez));
            check($sformatf("vec%0d_c", i), 32'(fc), 32'(vt[i].ec));
            check($sformatf("vec%0d_pc", i), 32'(pc), 32'(k));
        end

        // Branches: address 2 and 3 must never be fetched
        clear_prog();
        prog[0] = {LDI, 16'd0};
        prog[1] = {JZ, 16'd4};
        prog[2] = {LDI, 16'd7};
        prog[3] = {HLT, 16'd0};
        prog[4] = {LDI, 16'd9};
        prog[5] = {JNZ, 16'd7};
        prog[6] = {NOP, 16'd0};
        prog[7] = {HLT, 16'd0};
        exp_log[0] = 16'd0; exp_log[1] = 16'd1; exp_log[2] = 16'd4;
        exp_log[3] = 16'd5; exp_log[4] = 16'd7;
        run_prog(200, cyc);
        check("branch_acc", 32'(acc), 32'd9);
        check("branch_pc", 32'(pc), 32'd7);
        check("branch_cycles", 32'(cyc), 32'd10);
        check("branch_fetch_count", 32'(fetch_log.size()), 32'd5);
        if (fetch_log.size() == 5) begin
            for (int i = 0; i < 5; i++)
                check($sformatf("branch_fetch%0d", i), 32'(fetch_log[i]), 32'(exp_log[i]));
        end

        // Illegal opcode at pc 0, then asynchronous reset clears illegal
        clear_prog();
        prog[0] = {8'h42, 16'h0000};
        run_prog(200, cyc);
        check("illegal_flag", 32'(illegal), 32'd1);
        check("illegal_pc", 32'(pc), 32'd0);
        check("illegal_cycles", 32'(cyc), 32'd2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear_illegal", 32'(illegal), 32'd0);
        check("async_clear_halted", 32'(halted), 32'd0);

        // Asynchronous reset in the EXEC cycle of an ST
        clear_prog();
        prog[0] = {LDI, 16'd5};
        prog[1] = {ST, 16'd3};
        prog[2] = {HLT, 16'd0};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (pc == 16'd1 && !bus.imem_req && acc == 16'd5) begin
                found = 1'b1;
                break;
            end
        end
        check("st_exec_reached", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midexec_reset_acc", 32'(acc), 32'd0);
        check("midexec_reset_pc", 32'(pc), 32'd0);
        check("midexec_reset_req", 32'(bus.imem_req), 32'd0);
        clear_prog();
        prog[0] = {LD, 16'd3};
        prog[1] = {HLT, 16'd0};
        run_prog(200, cyc);
        check("rerun_acc", 32'(acc), 32'd0);
        check("rerun_z", 32'(fz), 32'd1);
        check("rerun_pc", 32'(pc), 32'd1);

        // PC wrap on the 4-bit instance
        repeat (2) @(negedge clk);
        rst4_n = 1'b1;
        wrap  = 1'b0;
        prev4 = 4'd0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (prev4 == 4'd15 && pc4 == 4'd0) wrap = 1'b1;
            prev4 = pc4;
            if (halted4) break;
        end
        check("wrap_halted", 32'(halted4), 32'd1);
        check("wrap_seen", 32'(wrap), 32'd1);
        check("wrap_pc", 32'(pc4), 32'd0);
        check("wrap_illegal", 32'(illegal4), 32'd0);
        check("wrap_state", {acc4, 14'd0, fz4, fc4}, 32'd0);

        // Random programs with forward jumps, random waits and stray acks
        ops = '{NOP, LDI, LD, ST, ADD, SUB, ANDO, ORO, XORO, ADDI, JMP, JZ, JNZ, JC};
        stray = 1'b1;
        for (int it = 0; it < 25; it++) begin
            int len;
            clear_prog();
            len = $urandom_range(6, 20);
            for (int p = 0; p < len - 1; p++) begin
                logic [7:0]  op;
                logic [15:0] imm;
                op  = ops[$urandom_range(0, 13)];
                imm = 16'($urandom);
                if ($urandom_range(0, 7) == 0) imm = 16'hFFFF;
                if (op >= JMP) imm = 16'($urandom_range(p + 1, len - 1));
                prog[p] = {op, imm};
            end
            case ($urandom_range(0, 5))
                0: prog[len - 1] = {8'h42, 16'h0};
                1: prog[len - 1] = {8'h0A, 16'h0};
                default: prog[len - 1] = {HLT, 16'h0};
            endcase
            wait_n = $urandom_range(0, 3);
            model(e_acc, e_z, e_c, e_ill, e_pc, e_n);
            run_prog(2000, cyc);
            check($sformatf("rnd%0d_acc", it), 32'(acc), e_acc);
            check($sformatf("rnd%0d_z", it), 32'(fz), 32'(e_z));
            check($sformatf("rnd%0d_c", it), 32'(fc), 32'(e_c));
            check($sformatf("rnd%0d_pc", it), 32'(pc), e_pc);
            check($sformatf("rnd%0d_illegal", it), 32'(illegal), 32'(e_ill));
            check($sformatf("rnd%0d_cycles", it), 32'(cyc), e_n * (2 + 32'(wait_n)));
        end
        stray  = 1'b0;
        wait_n = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
